seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: start  input  1  request a division; sampled only in IDLE.
REQ-005 Port: dividend  input  WIDTH  numerator; captured on the accepted start edge.
REQ-006 Port: divisor  input  WIDTH  denominator; captured on the accepted start edge.
REQ-007 Port: busy  output  1  high in the CALC and DONE states.
REQ-008 Port: done  output  1  one-cycle pulse; results are valid from this cycle onward.
REQ-009 Port: quotient  output  WIDTH  result quotient.
REQ-010 Port: remainder  output  WIDTH  result remainder.
REQ-011 Port: div_by_zero  output  1  set when the captured divisor was zero.

Function
REQ-012 FSM states: IDLE, CALC, DONE.
- IDLE->CALC: start=1 and divisor!=0.
- IDLE->DONE: start=1 and divisor==0.
- CALC->DONE: after WIDTH iterations.
- DONE->IDLE: unconditionally after one cycle.
REQ-013 CALC shall perform one restoring shift-subtract step per cycle, MSB first, using a WIDTH+1-bit partial remainder.
REQ-014 Latency: done asserts exactly WIDTH+1 cycles after the start-sampling edge for nonzero divisor, and 1 cycle after it for a zero divisor.
REQ-015 start while busy=1 shall be ignored, with no effect on the captured operands or the in-flight result.
REQ-016 Divide by zero: quotient = all ones, remainder = dividend, div_by_zero = 1.
REQ-017 Hold: quotient, remainder and div_by_zero keep their values until the next accepted start.
- On that start, div_by_zero clears, or sets for a zero divisor.
REQ-018 Intermediate quotient/remainder values may be visible during CALC; only values qualified by done are defined.
REQ-019 start asserted in the DONE cycle shall be ignored; start is accepted from the following IDLE cycle.
REQ-020 dividend < divisor: quotient = 0, remainder = dividend, full WIDTH+1 latency.

Reset
REQ-021 rst=1 shall immediately force:
- state = IDLE;
- busy, done, div_by_zero = 0;
- quotient, remainder = 0;
- iteration counter = 0.
REQ-022 rst asserted mid-CALC shall abort the operation with no done pulse; the first start after rst deasserts shall be accepted normally.

Configuration
REQ-023 Macro: SEQ_DIVIDER_SIGNED_EN.
REQ-024 With SEQ_DIVIDER_SIGNED_EN defined:
- operands and results are two's complement;
- the core divides magnitudes, then corrects signs;
- quotient truncates toward zero and the remainder takes the sign of the dividend;
- the sign-correction cycle adds one cycle, giving a nonzero-divisor latency of WIDTH+2;
- most-negative / -1 yields quotient = most-negative and remainder = 0;
- a zero divisor still follows REQ-016.
REQ-025 Without SEQ_DIVIDER_SIGNED_EN: unsigned only, with no correction logic or cycle.

Structure
REQ-026 Package divider_pkg shall hold:
- the FSM state enum (IDLE, CALC, DONE);
- the default WIDTH constant;
- the counter-width function clog2(WIDTH+1).
REQ-027 Sub-module divider_step: one combinational restoring iteration.
- Inputs: partial remainder, next dividend bit, divisor.
- Outputs: new partial remainder, quotient bit.
- seq_divider instantiates it once.

Verification (WIDTH=8)
REQ-028 8/2, start pulse -> done at cycle 9 after start; quotient=4, remainder=0, div_by_zero=0.
REQ-029 255/4 -> quotient=63, remainder=3; a second start pulse mid-CALC (7/3) is ignored and the result is unchanged.
REQ-030 9/0 -> done 1 cycle after start; quotient=255, remainder=9, div_by_zero=1; next 7/3 -> quotient=2, remainder=1, div_by_zero=0.
REQ-031 200/13 started, rst pulsed at CALC cycle 4 -> no done and all outputs 0; then 200/13 -> quotient=15, remainder=5.
REQ-032 Back-to-back: 3/7 then, on the first IDLE cycle, 100/10 -> (0,3) then (10,0), each with exactly one done pulse.
REQ-033 SEQ_DIVIDER_SIGNED_EN defined:
- -7/2 -> (-3,-1), done at cycle 10;
- -128/-1 -> (-128,0);
- 7/-2 -> (-3,1).

Source files
------------

// File: rtl/divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state
// encoding, default operand width and the iteration-counter width helper.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Counter must be able to hold the value WIDTH (signed build uses it).
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/divider_step.sv
// One combinational restoring shift-subtract iteration: shift the partial
// remainder left, bring in the next dividend bit, subtract the divisor when
// it fits and report the resulting quotient bit.
module divider_step
    import divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   part_in,
    input  logic             next_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   part_out,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;

    // Trial subtraction; a set MSB in the incoming remainder means the
    // shifted value exceeds any WIDTH-bit divisor, so it always fits.
    always_comb begin
        shifted = {part_in[WIDTH-1:0], next_bit};
        diff    = {1'b0, shifted} - {2'b00, divisor};
        q_bit   = part_in[WIDTH] | ~diff[WIDTH+1];
        if (q_bit) begin
            part_out = diff[WIDTH:0];
        end else begin
            part_out = shifted;
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock, MSB first.
// Optional two's-complement mode is enabled by defining the macro
// SEQ_DIVIDER_SIGNED_EN; it divides magnitudes and spends one extra CALC
// cycle applying sign correction. The default build is unsigned only.
module seq_divider
    import divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);
`ifdef SEQ_DIVIDER_SIGNED_EN
    // WIDTH shift-subtract steps plus one sign-correction step.
    localparam logic [CW-1:0] LAST = CW'(WIDTH);
`else
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`endif
    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};

    state_t           state;
    state_t           next_state;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH:0]   part_r;
    logic [WIDTH-1:0] dvs_r;
    logic             dbz_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH:0]   step_part_s;
    logic             step_q_s;
    logic             divisor_zero_s;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic             neg_q_r;
    logic             neg_rem_r;

    // Magnitude of a two's-complement value; the most-negative value maps
    // to itself, which is the correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    // Two's-complement negation.
    function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction
`endif

    assign divisor_zero_s = (divisor == ZERO_W);

    // quo_r doubles as the dividend shift register: its MSB feeds the step.
    divider_step #(.WIDTH(WIDTH)) u_step (
        .part_in  (part_r),
        .next_bit (quo_r[WIDTH-1]),
        .divisor  (dvs_r),
        .part_out (step_part_s),
        .q_bit    (step_q_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; start is only looked at while idle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (divisor_zero_s) begin
                        next_state = DONE;
                    end else begin
                        next_state = CALC;
                    end
                end else begin
                    next_state = IDLE;
                end
            end
            CALC: begin
                if (count_r == LAST) begin
                    next_state = DONE;
                end else begin
                    next_state = CALC;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Registered status flags derived from the upcoming state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (next_state != IDLE);
            done_r <= (next_state == DONE);
        end
    end

    // Datapath: operand capture, iteration and result hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r   <= {CW{1'b0}};
            quo_r     <= ZERO_W;
            part_r    <= {(WIDTH+1){1'b0}};
            dvs_r     <= ZERO_W;
            dbz_r     <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_q_r   <= 1'b0;
            neg_rem_r <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        count_r <= {CW{1'b0}};
                        dbz_r   <= divisor_zero_s;
                        if (divisor_zero_s) begin
                            // Raw dividend as remainder, in both modes.
                            quo_r  <= ONES_W;
                            part_r <= {1'b0, dividend};
                            dvs_r  <= ZERO_W;
                        end else begin
                            part_r <= {(WIDTH+1){1'b0}};
`ifdef SEQ_DIVIDER_SIGNED_EN
                            quo_r     <= mag(dividend);
                            dvs_r     <= mag(divisor);
                            neg_q_r   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            neg_rem_r <= dividend[WIDTH-1];
`else
                            quo_r <= dividend;
                            dvs_r <= divisor;
`endif
                        end
                    end else begin
                        count_r <= count_r;
                    end
                end
                CALC: begin
                    count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
`ifdef SEQ_DIVIDER_SIGNED_EN
                    if (count_r == LAST) begin
                        if (neg_q_r) begin
                            quo_r <= neg(quo_r);
                        end else begin
                            quo_r <= quo_r;
                        end
                        if (neg_rem_r) begin
                            part_r <= {1'b0, neg(part_r[WIDTH-1:0])};
                        end else begin
                            part_r <= part_r;
                        end
                    end else begin
                        quo_r  <= {quo_r[WIDTH-2:0], step_q_s};
                        part_r <= step_part_s;
                    end
`else
                    quo_r  <= {quo_r[WIDTH-2:0], step_q_s};
                    part_r <= step_part_s;
`endif
                end
                DONE: begin
                    count_r <= {CW{1'b0}};
                end
                default: begin
                    count_r <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign quotient    = quo_r;
    assign remainder   = part_r[WIDTH-1:0];
    assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH=8). Expected values
// are hand-computed; the signed vectors apply when SEQ_DIVIDER_SIGNED_EN
// is defined for both bench and design.
module tb_seq_divider;

`ifdef SEQ_DIVIDER_SIGNED_EN
    localparam int LAT = 10;
`else
    localparam int LAT = 9;
`endif

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int errors;
    int checks;

    seq_divider #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one start pulse and watch 40 cycles: first done cycle, results
    // captured at that cycle, and total number of done pulses.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          output int lat, output logic [7:0] q,
                          output logic [7:0] r, output logic z,
                          output int pulses);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        lat    = -1;
        pulses = 0;
        q      = 8'h00;
        r      = 8'h00;
        z      = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (done === 1'b1) begin
                pulses++;
                if (lat < 0) begin
                    lat = n;
                    q   = quotient;
                    r   = remainder;
                    z   = div_by_zero;
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = 8'h00;
        divisor  = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, div_by_zero, quotient, remainder} !== 19'd0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b dbz=%b q=%0d r=%0d, want all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_release_idle: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_basic;
        int lat; int pulses; logic [7:0] q; logic [7:0] r; logic z;
        run_op(8'd8, 8'd2, lat, q, r, z, pulses);
        checks++;
        if (lat !== LAT) begin
            errors++;
            $display("FAIL basic_latency: got %0d, want %0d", lat, LAT);
        end
        checks++;
        if ({q, r, z} !== {8'd4, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL basic_8_2: got q=%0d r=%0d dbz=%b, want 4 0 0", q, r, z);
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL basic_pulses: got %0d, want 1", pulses);
        end
    endtask

    task automatic test_ignore_busy;
        int lat; int pulses;
        logic [7:0] q; logic [7:0] r; logic bsy;
        logic [7:0] exp_q; logic [7:0] exp_r;
`ifdef SEQ_DIVIDER_SIGNED_EN
        exp_q = 8'd0;   exp_r = 8'hFF;   // -1 / 4
`else
        exp_q = 8'd63;  exp_r = 8'd3;    // 255 / 4
`endif
        @(negedge clk);
        dividend = 8'd255;
        divisor  = 8'd4;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = -1; pulses = 0; q = 8'h00; r = 8'h00; bsy = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            if (n == 3) begin
                bsy      = busy;
                dividend = 8'd7;
                divisor  = 8'd3;
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                pulses++;
                if (lat < 0) begin
                    lat = n; q = quotient; r = remainder;
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (bsy !== 1'b1) begin
            errors++;
            $display("FAIL busy_in_calc: got %b, want 1", bsy);
        end
        checks++;
        if ({q, r} !== {exp_q, exp_r} || lat !== LAT) begin
            errors++;
            $display("FAIL ignore_busy_start: got q=%0d r=%0d lat=%0d, want %0d %0d %0d",
                     q, r, lat, exp_q, exp_r, LAT);
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL ignore_busy_pulses: got %0d, want 1", pulses);
        end
    endtask

    task automatic test_div_zero;
        int lat; int pulses; logic [7:0] q; logic [7:0] r; logic z;
        int extra;
        @(negedge clk);
        dividend = 8'd9;
        divisor  = 8'd0;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({done, busy, quotient, remainder, div_by_zero} !== {1'b1, 1'b1, 8'd255, 8'd9, 1'b1}) begin
            errors++;
            $display("FAIL div_zero_first_cycle: got done=%b busy=%b q=%0d r=%0d dbz=%b, want 1 1 255 9 1",
                     done, busy, quotient, remainder, div_by_zero);
        end
        // start held during the DONE cycle must be ignored
        dividend = 8'd7;
        divisor  = 8'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL done_one_cycle: got done=%b busy=%b, want 0 0", done, busy);
        end
        extra = 0;
        for (int n = 0; n < 12; n++) begin
            if (done === 1'b1 || busy === 1'b1) extra++;
            @(negedge clk);
        end
        checks++;
        if (extra !== 0 || {quotient, remainder, div_by_zero} !== {8'd255, 8'd9, 1'b1}) begin
            errors++;
            $display("FAIL start_in_done_ignored: got activity=%0d q=%0d r=%0d dbz=%b, want 0 255 9 1",
                     extra, quotient, remainder, div_by_zero);
        end
        run_op(8'd7, 8'd3, lat, q, r, z, pulses);
        checks++;
        if ({q, r, z} !== {8'd2, 8'd1, 1'b0} || lat !== LAT) begin
            errors++;
            $display("FAIL after_div_zero_7_3: got q=%0d r=%0d dbz=%b lat=%0d, want 2 1 0 %0d",
                     q, r, z, lat, LAT);
        end
    endtask

    task automatic test_reset_abort;
        int lat; int pulses; logic [7:0] q; logic [7:0] r; logic z;
        logic [7:0] exp_q; logic [7:0] exp_r;
`ifdef SEQ_DIVIDER_SIGNED_EN
        exp_q = 8'hFC;  exp_r = 8'hFC;   // -56 / 13
`else
        exp_q = 8'd15;  exp_r = 8'd5;    // 200 / 13
`endif
        @(negedge clk);
        dividend = 8'd200;
        divisor  = 8'd13;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, div_by_zero, quotient, remainder} !== 19'd0) begin
            errors++;
            $display("FAIL reset_abort_outputs: got busy=%b done=%b dbz=%b q=%0d r=%0d, want all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int n = 0; n < 15; n++) begin
            if (done === 1'b1) pulses++;
            @(negedge clk);
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL reset_abort_no_done: got %0d pulses, want 0", pulses);
        end
        run_op(8'd200, 8'd13, lat, q, r, z, pulses);
        checks++;
        if ({q, r} !== {exp_q, exp_r} || lat !== LAT || pulses !== 1) begin
            errors++;
            $display("FAIL after_reset_200_13: got q=%0d r=%0d lat=%0d pulses=%0d, want %0d %0d %0d 1",
                     q, r, lat, pulses, exp_q, exp_r, LAT);
        end
    endtask

    task automatic test_back_to_back;
        int lat1; int lat2; int pulses;
        logic [7:0] q1; logic [7:0] r1; logic [7:0] q2; logic [7:0] r2;
        logic done_after;
        @(negedge clk);
        dividend = 8'd3;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat1 = -1; q1 = 8'h00; r1 = 8'h00;
        for (int n = 1; n <= 20 && lat1 < 0; n++) begin
            if (done === 1'b1) begin
                lat1 = n; q1 = quotient; r1 = remainder;
            end else begin
                @(negedge clk);
            end
        end
        // next cycle is the first IDLE cycle: issue the second start
        @(negedge clk);
        done_after = done;
        dividend = 8'd100;
        divisor  = 8'd10;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat2 = -1; pulses = 0; q2 = 8'h00; r2 = 8'h00;
        for (int n = 1; n <= 20; n++) begin
            if (done === 1'b1) begin
                pulses++;
                if (lat2 < 0) begin
                    lat2 = n; q2 = quotient; r2 = remainder;
                end
            end
            @(negedge clk);
        end
        checks++;
        if ({q1, r1} !== {8'd0, 8'd3} || lat1 !== LAT || done_after !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first_3_7: got q=%0d r=%0d lat=%0d done_next=%b, want 0 3 %0d 0",
                     q1, r1, lat1, done_after, LAT);
        end
        checks++;
        if ({q2, r2} !== {8'd10, 8'd0} || lat2 !== LAT || pulses !== 1) begin
            errors++;
            $display("FAIL b2b_second_100_10: got q=%0d r=%0d lat=%0d pulses=%0d, want 10 0 %0d 1",
                     q2, r2, lat2, pulses, LAT);
        end
    endtask

    // Operand table: dividend, divisor, expected quotient, expected remainder.
    task automatic test_boundary;
        logic [7:0] vec [4][4];
        int lat; int pulses; logic [7:0] q; logic [7:0] r; logic z;
`ifdef SEQ_DIVIDER_SIGNED_EN
        vec[0] = '{8'hF9, 8'h02, 8'hFD, 8'hFF};   // -7 / 2
        vec[1] = '{8'h80, 8'hFF, 8'h80, 8'h00};   // -128 / -1
        vec[2] = '{8'h07, 8'hFE, 8'hFD, 8'h01};   // 7 / -2
        vec[3] = '{8'h64, 8'hF6, 8'hF6, 8'h00};   // 100 / -10
`else
        vec[0] = '{8'd255, 8'd1,   8'd255, 8'd0};
        vec[1] = '{8'd0,   8'd5,   8'd0,   8'd0};
        vec[2] = '{8'd255, 8'd255, 8'd1,   8'd0};
        vec[3] = '{8'd254, 8'd255, 8'd0,   8'd254};
`endif
        for (int i = 0; i < 4; i++) begin
            run_op(vec[i][0], vec[i][1], lat, q, r, z, pulses);
            checks++;
            if ({q, r, z} !== {vec[i][2], vec[i][3], 1'b0} || lat !== LAT || pulses !== 1) begin
                errors++;
                $display("FAIL boundary_%0d: %0d/%0d got q=%0d r=%0d dbz=%b lat=%0d pulses=%0d, want %0d %0d 0 %0d 1",
                         i, vec[i][0], vec[i][1], q, r, z, lat, pulses, vec[i][2], vec[i][3], LAT);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_basic();
        test_ignore_busy();
        test_div_zero();
        test_reset_abort();
        test_back_to_back();
        test_boundary();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
